// File: rtl/gat_loader_pkg.sv
// Shared types and constants for the GAT BRAM loader: FSM state encoding,
// read-FIFO depth and the word-index to byte-address helper.
package gat_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_H,
        LOAD_NI,
        LOAD_W,
        WAIT_GAT,
        READ
    } state_t;

    localparam int FIFO_DEPTH = 4;

    function automatic logic [31:0] byte_addr(input logic [31:0] idx);
        return idx << 2;
    endfunction

endpackage

// File: rtl/gat_feat_rd_fifo.sv
// Small synchronous FIFO buffering feature-BRAM read data ahead of the
// output stream; exposes its occupancy so the issuer can bound reads.
module gat_feat_rd_fifo
    import gat_loader_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = FIFO_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic [CNT_W-1:0] o_count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_wr;
    logic             w_rd;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_rd    = i_pop && !w_empty;
    // A push into a full FIFO is accepted when a pop frees a slot on the same edge.
    assign w_wr    = i_push && (!w_full || w_rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (w_rd) r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/gat_bram_loader.sv
// Host-side initiator for the GAT accelerator: streams words into the H-data,
// node-info and weight BRAMs, waits for gat_ready, then streams features back.
module gat_bram_loader
    import gat_loader_pkg::*;
#(
    parameter int DATA_WIDTH         = 8,
    parameter int H_DATA_DEPTH       = 242101,
    parameter int NODE_INFO_DEPTH    = 13264,
    parameter int WEIGHT_DEPTH       = 22928,
    parameter int NEW_FEATURE_DEPTH  = 43328,
    parameter int FEAT_RD_LAT        = 2,
    parameter int H_DATA_ADDR_W      = $clog2(H_DATA_DEPTH),
    parameter int NODE_INFO_ADDR_W   = $clog2(NODE_INFO_DEPTH),
    parameter int WEIGHT_ADDR_W      = $clog2(WEIGHT_DEPTH),
    parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [31:0]                   s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [31:0]                   h_data_bram_din,
    output logic                          h_data_bram_ena,
    output logic                          h_data_bram_wea,
    output logic [H_DATA_ADDR_W+1:0]      h_data_bram_addra,
    output logic [31:0]                   h_node_info_bram_din,
    output logic                          h_node_info_bram_ena,
    output logic                          h_node_info_bram_wea,
    output logic [NODE_INFO_ADDR_W+1:0]   h_node_info_bram_addra,
    output logic [31:0]                   wgt_bram_din,
    output logic                          wgt_bram_ena,
    output logic                          wgt_bram_wea,
    output logic [WEIGHT_ADDR_W+1:0]      wgt_bram_addra,
    output logic                          h_data_bram_load_done,
    output logic                          h_node_info_bram_load_done,
    output logic                          wgt_bram_load_done,
    input  logic                          gat_ready,
    output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
    input  logic [31:0]                   feat_bram_dout,
    output logic [31:0]                   m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          busy,
    output logic                          done
);
    localparam int LD_HN_W  = (H_DATA_ADDR_W > NODE_INFO_ADDR_W) ? H_DATA_ADDR_W : NODE_INFO_ADDR_W;
    localparam int LD_CNT_W = (LD_HN_W > WEIGHT_ADDR_W) ? LD_HN_W : WEIGHT_ADDR_W;
    localparam int RD_W     = $clog2(NEW_FEATURE_DEPTH + 1);
    localparam int FCNT_W   = $clog2(FIFO_DEPTH + 1);

    state_t                          r_state;
    logic [LD_CNT_W-1:0]             r_cnt;
    logic [31:0]                     r_wr_data;
    logic                            r_h_ena, r_ni_ena, r_w_ena;
    logic [H_DATA_ADDR_W+1:0]        r_h_addra;
    logic [NODE_INFO_ADDR_W+1:0]     r_ni_addra;
    logic [WEIGHT_ADDR_W+1:0]        r_w_addra;
    logic                            r_h_done, r_ni_done, r_w_done;
    logic                            r_gat_q, r_gat_prev;
    logic [RD_W-1:0]                 r_rd_issued, r_rd_popped;
    logic [NEW_FEATURE_ADDR_W+1:0]   r_addrb;
    logic [FEAT_RD_LAT:0]            r_rd_vpipe;
    logic                            r_done;

    logic                            w_accept;
    logic                            w_issue;
    logic                            w_pop;
    logic [RD_W-1:0]                 w_outst;
    logic [31:0]                     w_fifo_din;
    logic [31:0]                     w_fifo_dout;
    logic [FCNT_W-1:0]               w_fifo_cnt;
    logic                            w_unused_dout;

    assign s_ready  = (r_state == LOAD_H) || (r_state == LOAD_NI) || (r_state == LOAD_W);
    assign w_accept = s_valid && s_ready;
    assign w_outst  = r_rd_issued - r_rd_popped;
    // Outstanding count covers in-flight reads plus FIFO contents, so the FIFO can never overflow.
    assign w_issue  = (r_state == READ) && (r_rd_issued < RD_W'(NEW_FEATURE_DEPTH))
                      && (32'(w_outst) < 32'(FIFO_DEPTH));
    assign m_valid  = (w_fifo_cnt != '0);
    assign w_pop    = m_valid && m_ready;

    assign w_fifo_din    = 32'($signed(feat_bram_dout[DATA_WIDTH-1:0]));
    assign w_unused_dout = ^feat_bram_dout[31:DATA_WIDTH];

    gat_feat_rd_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (FCNT_W)
    ) u_rd_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_rd_vpipe[FEAT_RD_LAT]),
        .i_din   (w_fifo_din),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_count (w_fifo_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_wr_data   <= '0;
            r_h_ena     <= 1'b0;
            r_ni_ena    <= 1'b0;
            r_w_ena     <= 1'b0;
            r_h_addra   <= '0;
            r_ni_addra  <= '0;
            r_w_addra   <= '0;
            r_h_done    <= 1'b0;
            r_ni_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_gat_q     <= 1'b0;
            r_gat_prev  <= 1'b0;
            r_rd_issued <= '0;
            r_rd_popped <= '0;
            r_addrb     <= '0;
            r_rd_vpipe  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_h_ena    <= 1'b0;
            r_ni_ena   <= 1'b0;
            r_w_ena    <= 1'b0;
            r_done     <= 1'b0;
            r_gat_q    <= gat_ready;
            r_gat_prev <= r_gat_q;
            r_rd_vpipe <= {r_rd_vpipe[FEAT_RD_LAT-1:0], w_issue};
            // A strobe seen after the state has moved on is the segment's final write.
            if (r_h_ena  && r_state != LOAD_H)  r_h_done  <= 1'b1;
            if (r_ni_ena && r_state != LOAD_NI) r_ni_done <= 1'b1;
            if (r_w_ena  && r_state != LOAD_W)  r_w_done  <= 1'b1;
            case (r_state)
                IDLE: if (start) begin
                    r_h_done    <= 1'b0;
                    r_ni_done   <= 1'b0;
                    r_w_done    <= 1'b0;
                    r_cnt       <= '0;
                    r_rd_issued <= '0;
                    r_rd_popped <= '0;
                    r_state     <= LOAD_H;
                end
                LOAD_H: if (w_accept) begin
                    r_wr_data <= s_data;
                    r_h_ena   <= 1'b1;
                    r_h_addra <= (H_DATA_ADDR_W+2)'(byte_addr(32'(r_cnt)));
                    if (r_cnt == LD_CNT_W'(H_DATA_DEPTH - 1)) begin
                        r_cnt   <= '0;
                        r_state <= LOAD_NI;
                    end else r_cnt <= r_cnt + LD_CNT_W'(1);
                end
                LOAD_NI: if (w_accept) begin
                    r_wr_data  <= s_data;
                    r_ni_ena   <= 1'b1;
                    r_ni_addra <= (NODE_INFO_ADDR_W+2)'(byte_addr(32'(r_cnt)));
                    if (r_cnt == LD_CNT_W'(NODE_INFO_DEPTH - 1)) begin
                        r_cnt   <= '0;
                        r_state <= LOAD_W;
                    end else r_cnt <= r_cnt + LD_CNT_W'(1);
                end
                LOAD_W: if (w_accept) begin
                    r_wr_data <= s_data;
                    r_w_ena   <= 1'b1;
                    r_w_addra <= (WEIGHT_ADDR_W+2)'(byte_addr(32'(r_cnt)));
                    if (r_cnt == LD_CNT_W'(WEIGHT_DEPTH - 1)) begin
                        r_cnt   <= '0;
                        r_state <= WAIT_GAT;
                    end else r_cnt <= r_cnt + LD_CNT_W'(1);
                end
                WAIT_GAT: if (r_gat_q && !r_gat_prev) begin
                    r_rd_issued <= '0;
                    r_rd_popped <= '0;
                    r_state     <= READ;
                end
                READ: begin
                    if (w_issue) begin
                        r_addrb     <= (NEW_FEATURE_ADDR_W+2)'(byte_addr(32'(r_rd_issued)));
                        r_rd_issued <= r_rd_issued + RD_W'(1);
                    end
                    if (w_pop) begin
                        r_rd_popped <= r_rd_popped + RD_W'(1);
                        if (r_rd_popped == RD_W'(NEW_FEATURE_DEPTH - 1)) begin
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign h_data_bram_din            = r_wr_data;
    assign h_data_bram_ena            = r_h_ena;
    assign h_data_bram_wea            = r_h_ena;
    assign h_data_bram_addra          = r_h_addra;
    assign h_node_info_bram_din       = r_wr_data;
    assign h_node_info_bram_ena       = r_ni_ena;
    assign h_node_info_bram_wea       = r_ni_ena;
    assign h_node_info_bram_addra     = r_ni_addra;
    assign wgt_bram_din               = r_wr_data;
    assign wgt_bram_ena               = r_w_ena;
    assign wgt_bram_wea               = r_w_ena;
    assign wgt_bram_addra             = r_w_addra;
    assign h_data_bram_load_done      = r_h_done;
    assign h_node_info_bram_load_done = r_ni_done;
    assign wgt_bram_load_done         = r_w_done;
    assign feat_bram_addrb            = r_addrb;
    assign m_data                     = w_fifo_dout;
    assign busy                       = (r_state != IDLE);
    assign done                       = r_done;

endmodule

// File: tb/tb_gat_bram_loader.sv
// Scoreboard bench for gat_bram_loader: expected BRAM writes and read-back words
// are queued when stimulus is driven and compared as the DUT produces them.
`timescale 1ns/1ps
module tb_gat_bram_loader;
    localparam int H = 5, NI = 3, WD = 4, FEAT = 6, LAT = 2;
    localparam int HA = $clog2(H) + 2, NIA = $clog2(NI) + 2, WA = $clog2(WD) + 2, FA = $clog2(FEAT) + 2;
    localparam int TOTAL = H + NI + WD;

    logic            clk = 1'b0;
    logic            rst, start, s_valid, s_ready, gat_ready, m_valid, m_ready, busy, done;
    logic [31:0]     s_data, h_din, ni_din, w_din, feat_bram_dout, m_data;
    logic            h_ena, h_wea, ni_ena, ni_wea, w_ena, w_wea, h_ld, ni_ld, w_ld;
    logic [HA-1:0]   h_addra;
    logic [NIA-1:0]  ni_addra;
    logic [WA-1:0]   w_addra;
    logic [FA-1:0]   feat_bram_addrb;

    gat_bram_loader #(
        .DATA_WIDTH(8), .H_DATA_DEPTH(H), .NODE_INFO_DEPTH(NI), .WEIGHT_DEPTH(WD),
        .NEW_FEATURE_DEPTH(FEAT), .FEAT_RD_LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .h_data_bram_din(h_din), .h_data_bram_ena(h_ena), .h_data_bram_wea(h_wea), .h_data_bram_addra(h_addra),
        .h_node_info_bram_din(ni_din), .h_node_info_bram_ena(ni_ena), .h_node_info_bram_wea(ni_wea),
        .h_node_info_bram_addra(ni_addra),
        .wgt_bram_din(w_din), .wgt_bram_ena(w_ena), .wgt_bram_wea(w_wea), .wgt_bram_addra(w_addra),
        .h_data_bram_load_done(h_ld), .h_node_info_bram_load_done(ni_ld), .wgt_bram_load_done(w_ld),
        .gat_ready(gat_ready), .feat_bram_addrb(feat_bram_addrb), .feat_bram_dout(feat_bram_dout),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } wr_t;

    wr_t         wr_q[$];
    logic [31:0] rd_q[$];
    int          n_cmp = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Feature BRAM model: dout reflects the address presented LAT cycles earlier.
    logic [31:0]   mem [8] = '{default: '0};
    logic [FA-1:0] rd_pipe [LAT];
    always @(posedge clk) begin
        rd_pipe[0] <= feat_bram_addrb;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign feat_bram_dout = mem[rd_pipe[LAT-1][FA-1:2]];

    int          beats, popped, n_ena;
    logic [2:0]  exp_ld;
    bit          exp_busy, exp_done, run_end;
    wr_t         e;
    logic [1:0]  g_id;
    logic [31:0] g_addr, g_data, x;
    logic        g_wea;

    always @(negedge clk) begin
        if (rst) begin
            beats = 0; popped = 0; exp_ld = '0; exp_busy = 0; exp_done = 0;
            wr_q.delete();
        end else begin
            check("busy", 32'(busy), 32'(exp_busy));
            check("done", 32'(done), 32'(exp_done));
            check("s_ready", 32'(s_ready), 32'(exp_busy && beats < TOTAL));
            check("load_done", 32'({h_ld, ni_ld, w_ld}), 32'(exp_ld));
            exp_done = 0;
            n_ena = int'(h_ena) + int'(ni_ena) + int'(w_ena);
            if (n_ena != 0) begin
                check("one_ena", 32'(n_ena), 32'd1);
                if (h_ena)       begin g_id = 2'd0; g_addr = 32'(h_addra);  g_data = h_din;  g_wea = h_wea;  end
                else if (ni_ena) begin g_id = 2'd1; g_addr = 32'(ni_addra); g_data = ni_din; g_wea = ni_wea; end
                else             begin g_id = 2'd2; g_addr = 32'(w_addra);  g_data = w_din;  g_wea = w_wea;  end
                check("wea", 32'(g_wea), 32'd1);
                if (wr_q.size() == 0) check("wr_extra", 32'(n_ena), 32'd0);
                else begin
                    e = wr_q.pop_front();
                    check("wr_bram", 32'(g_id), 32'(e.id));
                    check("wr_addr", g_addr, e.addr);
                    check("wr_din", g_data, e.data);
                    if (e.last) exp_ld[2 - e.id] = 1'b1;
                end
            end
            if (m_valid) begin
                check("outstanding", 32'(int'(feat_bram_addrb >> 2) <= popped + 3), 32'd1);
                check("addrb_align", 32'(feat_bram_addrb[1:0]), 32'd0);
            end
            if (m_valid && m_ready) begin
                if (rd_q.size() == 0) check("rd_extra", 32'(m_valid), 32'd0);
                else check("m_data", m_data, rd_q.pop_front());
                popped++;
                if (popped == FEAT) begin exp_done = 1; exp_busy = 0; run_end = 1; end
            end
            if (s_valid && s_ready) begin
                if (beats < H)           e = '{2'd0, 32'(beats * 4),            s_data, beats == H - 1};
                else if (beats < H + NI) e = '{2'd1, 32'((beats - H) * 4),      s_data, beats == H + NI - 1};
                else                     e = '{2'd2, 32'((beats - H - NI) * 4), s_data, beats == TOTAL - 1};
                wr_q.push_back(e);
                beats++;
            end
            if (start && !exp_busy) begin exp_busy = 1; exp_ld = '0; beats = 0; popped = 0; end
        end
    end

    task automatic set_mem(input int run);
        logic [31:0] tab_a [FEAT];
        tab_a = '{32'h1234_5680, 32'hABCD_EF7F, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_00FE, 32'h55AA_0033};
        for (int i = 0; i < FEAT; i++) begin
            if (run == 0)      x = tab_a[i];
            else if (run == 1) x = 32'hA5A5_0000 | 32'((i * 53 + 96) & 255);
            else               x = 32'h0F0F_0000 | 32'((i * 71 + 3) & 255);
            mem[i] = x;
            rd_q.push_back({{24{x[7]}}, x[7:0]});
        end
    endtask

    task automatic pulse_start();
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input bit gap);
        bit          got = 0;
        int unsigned t   = 0;
        s_data = d; s_valid = 1'b1;
        while (!got && t < 50) begin
            @(negedge clk); got = s_ready;
            @(posedge clk); #1; t++;
        end
        if (!got) check("s_ready_timeout", 32'(s_ready), 32'd1);
        if (gap) begin s_valid = 1'b0; s_data = 32'hDEAD_BEEF; @(posedge clk); #1; end
    endtask

    task automatic wait_run_end();
        int unsigned t = 0;
        while (!run_end && t < 400) begin @(posedge clk); #1; t++; end
        if (!run_end) check("run_timeout", 32'(popped), 32'(FEAT));
        @(posedge clk); #1; @(posedge clk); #1;
        run_end = 0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; gat_ready = 1'b1; m_ready = 1'b0; run_end = 0;
        repeat (3) @(posedge clk); #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sready", 32'(s_ready), 32'd0);
        check("rst_ena", 32'({h_ena, ni_ena, w_ena}), 32'd0);
        check("rst_ld", 32'({h_ld, ni_ld, w_ld}), 32'd0);
        check("rst_mvalid", 32'(m_valid), 32'd0);
        check("rst_mdata", m_data, 32'd0);
        check("rst_addrb", 32'(feat_bram_addrb), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0; @(posedge clk); #1;

        // Run A: continuous stream, stale gat_ready, sign-extending readback.
        m_ready = 1'b1;
        set_mem(0);
        pulse_start();
        for (int i = 1; i <= TOTAL; i++) send_word(32'(i), 1'b0);
        s_valid = 1'b0;
        repeat (20) @(posedge clk); #1;
        check("stale_gat_no_read", 32'(m_valid), 32'd0);
        check("stale_gat_busy", 32'(busy), 32'd1);
        gat_ready = 1'b0; repeat (3) @(posedge clk); #1; gat_ready = 1'b1;
        wait_run_end();
        check("final_addrb", 32'(feat_bram_addrb), 32'd20);

        // Run B: gapped stream, output back-pressure mid-read.
        gat_ready = 1'b0;
        set_mem(1);
        pulse_start();
        for (int i = 0; i < TOTAL; i++) send_word(32'(100 + i), 1'b1);
        repeat (3) @(posedge clk); #1;
        gat_ready = 1'b1;
        for (int t = 0; t < 100 && popped < 1; t++) begin @(posedge clk); #1; end
        m_ready = 1'b0;
        repeat (10) @(posedge clk); #1;
        check("stall_valid", 32'(m_valid), 32'd1);
        m_ready = 1'b1;
        wait_run_end();

        // Run C: reset while loading node-info, then a complete fresh run.
        gat_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < H + 1; i++) send_word(32'(200 + i), 1'b0);
        rst = 1'b1; s_valid = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("abort_ld", 32'({h_ld, ni_ld, w_ld}), 32'd0);
        check("abort_ena", 32'({h_ena, ni_ena, w_ena}), 32'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("no_autostart", 32'(busy), 32'd0);
        set_mem(2);
        pulse_start();
        for (int i = 0; i < TOTAL; i++) send_word(32'(300 + i), 1'b0);
        s_valid = 1'b0;
        repeat (2) @(posedge clk); #1;
        gat_ready = 1'b1;
        wait_run_end();

        check("wr_q_left", 32'(wr_q.size()), 32'd0);
        check("rd_q_left", 32'(rd_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
